// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared types and constants for the two-port SDRAM
// request arbiter.
//   state_e    - arbiter FSM encoding (IDLE=0, BUSY=1, DONE=2)
//   port_idx_t - index of a requesting port (0 or 1)
//   ADDR_W / DATA_W / STRB_W - request field widths
package sdram_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic port_idx_t;

endpackage

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin arbiter in front of the SDRAM
// controller's single request port. The granted request is registered and
// held for the controller's multi-cycle access. The one-cycle completion
// pulse and read data are then returned to the winning port.
//   clk, rst_n                 - clock, synchronous active-low reset
//   sN_valid/addr/wdata/wstrb  - port N request (wstrb == 0 is a read)
//   sN_ready/sN_rdata          - port N completion pulse and read data
//   m_valid/addr/wdata/wstrb   - registered request to the controller
//   m_ready/m_rdata            - controller completion pulse and read data
// All outputs come straight from flops.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [STRB_W-1:0] s0_wstrb,
  output logic [DATA_W-1:0] s0_rdata,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [STRB_W-1:0] s1_wstrb,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic [DATA_W-1:0] m_rdata
);

  state_e              state_q, state_d;
  port_idx_t           grant_q, grant_d;
  port_idx_t           last_q, last_d;
  port_idx_t           winner;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
  logic                s0_ready_q, s0_ready_d;
  logic                s1_ready_q, s1_ready_d;
  logic [DATA_W-1:0]   s0_rdata_q, s0_rdata_d;
  logic [DATA_W-1:0]   s1_rdata_q, s1_rdata_d;

  // A lone requester wins outright; on contention the port that was not
  // granted last time wins.
  always_comb begin
    if (s0_valid && s1_valid) begin
      winner = ~last_q;
    end else begin
      winner = s1_valid;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DONE is an unconditional bubble so the master can drop
  // its valid before IDLE samples it again.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (s0_valid || s1_valid) state_d = ST_BUSY;
      ST_BUSY: if (m_ready) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    grant_d    = grant_q;
    last_d     = last_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wstrb_d  = m_wstrb_q;
    s0_ready_d = s0_ready_q;
    s1_ready_d = s1_ready_q;
    s0_rdata_d = s0_rdata_q;
    s1_rdata_d = s1_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s0_valid || s1_valid) begin
          grant_d   = winner;
          last_d    = winner;
          m_valid_d = 1'b1;
          m_addr_d  = winner ? s1_addr  : s0_addr;
          m_wdata_d = winner ? s1_wdata : s0_wdata;
          m_wstrb_d = winner ? s1_wstrb : s0_wstrb;
        end
      end
      ST_BUSY: begin
        // Completion is returned even if the master dropped valid meanwhile.
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (grant_q) begin
            s1_ready_d = 1'b1;
            s1_rdata_d = m_rdata;
          end else begin
            s0_ready_d = 1'b1;
            s0_rdata_d = m_rdata;
          end
        end
      end
      ST_DONE: begin
        s0_ready_d = 1'b0;
        s1_ready_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
      s0_ready_q <= 1'b0;
      s1_ready_q <= 1'b0;
      s0_rdata_q <= '0;
      s1_rdata_q <= '0;
    end else begin
      grant_q    <= grant_d;
      last_q     <= last_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wstrb_q  <= m_wstrb_d;
      s0_ready_q <= s0_ready_d;
      s1_ready_q <= s1_ready_d;
      s0_rdata_q <= s0_rdata_d;
      s1_rdata_q <= s1_rdata_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;
  assign s0_ready = s0_ready_q;
  assign s1_ready = s1_ready_q;
  assign s0_rdata = s0_rdata_q;
  assign s1_rdata = s1_rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: self-checking bench for sdram_arbiter. A controller
// model answers each request; the expected (port, rdata) completion is
// queued when m_ready is driven and checked when sN_ready appears.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [31:0] s0_addr = '0, s1_addr = '0;
  logic [31:0] s0_wdata = '0, s1_wdata = '0;
  logic [3:0]  s0_wstrb = '0, s1_wstrb = '0;
  logic [31:0] s0_rdata, s1_rdata;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = '0;

  int checks = 0;
  int passes = 0;
  logic mdl_last = 1'b1;

  typedef struct { logic port; logic [31:0] data; } exp_t;
  exp_t sb[$];

  sdram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_rdata(s1_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Completion monitor: every sN_ready pulse must match the oldest queued
  // completion; a pulse held for two cycles finds the queue empty.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic        rdy;
    logic [31:0] rd;
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        rdy = (p == 1) ? s1_ready : s0_ready;
        rd  = (p == 1) ? s1_rdata : s0_rdata;
        if (rdy === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            $display("FAIL unexpected_ready: port %0d ready, expected none", p);
          end else begin
            e = sb.pop_front();
            if (e.port !== (p == 1) || e.data !== rd)
              $display("FAIL completion: got port %0d rdata %h, expected port %0d rdata %h",
                       p, rd, e.port, e.data);
            else passes++;
          end
        end
      end
    end
  end

  // Controller model: waits (bounded) for m_valid, snapshots the request,
  // watches it stay stable for lat cycles, then pulses m_ready with d.
  // Returns on the negedge where the sN_ready response is visible.
  task automatic ctrl_cycle(input int lat, input logic [31:0] d, input logic port,
                            output int wcyc, output logic [31:0] a, output logic [31:0] w,
                            output logic [3:0] s, output bit stable);
    wcyc = -1; stable = 1'b1; a = '0; w = '0; s = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin wcyc = i; break; end
    end
    if (wcyc < 0) return;
    a = m_addr; w = m_wdata; s = m_wstrb;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (m_addr !== a || m_wdata !== w || m_wstrb !== s || m_valid !== 1'b1) stable = 1'b0;
    end
    m_ready = 1'b1;
    m_rdata = d;
    sb.push_back('{port, d});
    @(negedge clk);
    m_ready = 1'b0;
    m_rdata = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== '0)
      $display("FAIL reset_master: got %h, expected 0", {m_valid, m_addr, m_wdata, m_wstrb});
    else passes++;
    checks++;
    if ({s0_ready, s1_ready, s0_rdata, s1_rdata} !== '0)
      $display("FAIL reset_slave: got %h, expected 0", {s0_ready, s1_ready, s0_rdata, s1_rdata});
    else passes++;
    rst_n = 1'b1;
    mdl_last = 1'b1;
  endtask

  task automatic test_single_read();
    int wc; logic [31:0] a, w; logic [3:0] s; bit st;
    s0_addr = 32'h0000_1230; s0_wstrb = 4'h0; s0_wdata = $urandom; s0_valid = 1'b1;
    ctrl_cycle(8, 32'hDEAD_BEEF, 1'b0, wc, a, w, s, st);
    checks++;
    if (wc !== 1) $display("FAIL read_latency: got %0d cycles, expected 1", wc); else passes++;
    checks++;
    if (a !== 32'h0000_1230 || s !== 4'h0)
      $display("FAIL read_fields: got addr %h strb %h, expected 00001230/0", a, s);
    else passes++;
    checks++;
    if (!st) $display("FAIL read_stable: got unstable request, expected stable"); else passes++;
    checks++;
    if (s0_ready !== 1'b1 || s0_rdata !== 32'hDEAD_BEEF || s1_ready !== 1'b0 || s1_rdata !== '0)
      $display("FAIL read_resp: got s0 %b/%h s1 %b/%h, expected 1/deadbeef 0/0",
               s0_ready, s0_rdata, s1_ready, s1_rdata);
    else passes++;
    checks++;
    if (m_valid !== 1'b0) $display("FAIL read_mvalid_drop: got %b, expected 0", m_valid); else passes++;
    s0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s0_ready !== 1'b0 || s1_ready !== 1'b0)
      $display("FAIL read_pulse: got %b%b, expected 00", s0_ready, s1_ready);
    else passes++;
    @(negedge clk);
    mdl_last = 1'b0;
  endtask

  task automatic test_single_write();
    int wc; logic [31:0] a, w; logic [3:0] s; bit st;
    s1_addr = 32'h40; s1_wdata = 32'hA5A5_0F0F; s1_wstrb = 4'h3; s1_valid = 1'b1;
    ctrl_cycle(5, 32'h1357_9BDF, 1'b1, wc, a, w, s, st);
    checks++;
    if (wc !== 1) $display("FAIL write_latency: got %0d cycles, expected 1", wc); else passes++;
    checks++;
    if (a !== 32'h40 || w !== 32'hA5A5_0F0F || s !== 4'h3)
      $display("FAIL write_fields: got %h/%h/%h, expected 00000040/a5a50f0f/3", a, w, s);
    else passes++;
    checks++;
    if (!st) $display("FAIL write_stable: got unstable request, expected stable"); else passes++;
    checks++;
    if (s1_ready !== 1'b1 || s0_ready !== 1'b0 || s0_rdata !== 32'hDEAD_BEEF)
      $display("FAIL write_resp: got s1r %b s0r %b s0d %h, expected 1 0 deadbeef",
               s1_ready, s0_ready, s0_rdata);
    else passes++;
    s1_valid = 1'b0;
    repeat (2) @(negedge clk);
    mdl_last = 1'b1;
  endtask

  task automatic test_round_robin();
    int wc; logic [31:0] a, w; logic [3:0] s; bit st;
    logic exp_p; logic [31:0] exp_a;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_last = 1'b1;
    s0_addr = 32'h1000; s0_wstrb = '0; s1_addr = 32'h2000; s1_wstrb = '0;
    s0_valid = 1'b1; s1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_p = ~mdl_last;
      exp_a = exp_p ? s1_addr : s0_addr;
      ctrl_cycle(3 + k, 32'hC0DE_0000 + k, exp_p, wc, a, w, s, st);
      checks++;
      if (wc !== 1 || a !== exp_a)
        $display("FAIL rr_grant%0d: got wait %0d addr %h, expected 1 %h", k, wc, a, exp_a);
      else passes++;
      checks++;
      if (m_valid !== 1'b0) $display("FAIL rr_gap_a%0d: got m_valid %b, expected 0", k, m_valid);
      else passes++;
      if (exp_p) s1_addr = s1_addr + 4; else s0_addr = s0_addr + 4;
      mdl_last = exp_p;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0)
        $display("FAIL rr_gap_b%0d: got %b%b%b, expected 000", k, m_valid, s0_ready, s1_ready);
      else passes++;
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int wc; logic [31:0] a, w; logic [3:0] s; bit st;
    s0_addr = 32'h3000; s0_wstrb = '0; s0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ctrl_cycle(2, 32'hB2B0_0000 + k, 1'b0, wc, a, w, s, st);
      checks++;
      if (wc !== 1 || a !== s0_addr)
        $display("FAIL b2b_grant%0d: got wait %0d addr %h, expected 1 %h", k, wc, a, s0_addr);
      else passes++;
      s0_addr = s0_addr + 4;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) $display("FAIL b2b_gap%0d: got m_valid %b, expected 0", k, m_valid);
      else passes++;
    end
    s0_valid = 1'b0;
    repeat (2) @(negedge clk);
    mdl_last = 1'b0;
  endtask

  task automatic test_spurious_ready();
    int wc; logic [31:0] a, w; logic [3:0] s; bit st;
    m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    m_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || m_valid !== 1'b0)
        $display("FAIL spurious%0d: got %b%b%b, expected 000", k, s0_ready, s1_ready, m_valid);
      else passes++;
      @(negedge clk);
    end
    s1_addr = 32'h5000; s1_wstrb = '0; s1_valid = 1'b1;
    ctrl_cycle(2, 32'h600D_F00D, 1'b1, wc, a, w, s, st);
    checks++;
    if (wc !== 1 || a !== 32'h5000 || s1_ready !== 1'b1)
      $display("FAIL spurious_after: got wait %0d addr %h s1r %b, expected 1 00005000 1",
               wc, a, s1_ready);
    else passes++;
    s1_valid = 1'b0;
    repeat (2) @(negedge clk);
    mdl_last = 1'b1;
  endtask

  task automatic test_reset_mid_busy();
    int wc; logic [31:0] a, w; logic [3:0] s; bit st; bit seen;
    s1_addr = 32'h80; s1_wstrb = 4'hF; s1_wdata = 32'h1234_5678; s1_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL midrst_grant: got no m_valid, expected grant"); else passes++;
    @(negedge clk);
    rst_n = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_last = 1'b1;
    checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== '0)
      $display("FAIL midrst_master: got %h, expected 0", {m_valid, m_addr, m_wdata, m_wstrb});
    else passes++;
    checks++;
    if ({s0_ready, s1_ready, s0_rdata, s1_rdata} !== '0)
      $display("FAIL midrst_slave: got %h, expected 0", {s0_ready, s1_ready, s0_rdata, s1_rdata});
    else passes++;
    s0_addr = 32'h7000; s0_wstrb = '0; s1_addr = 32'h8000; s1_wstrb = '0;
    s0_valid = 1'b1; s1_valid = 1'b1;
    ctrl_cycle(3, 32'h0BAD_CAFE, ~mdl_last, wc, a, w, s, st);
    checks++;
    if (wc !== 1 || a !== 32'h7000)
      $display("FAIL midrst_tie: got wait %0d addr %h, expected 1 00007000", wc, a);
    else passes++;
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single_read();
    test_single_write();
    test_round_robin();
    test_back_to_back();
    test_spurious_ready();
    test_reset_mid_busy();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port round-robin arbiter sitting directly upstream of the SDRAM controller's single request port (`valid`/`ready`/`addr`/`wdata`/`wstrb`/`rdata`). It lets two masters (typically CPU instruction fetch on port 0 and data/DMA on port 1) share one SDRAM. It registers the granted request and holds it stable for the controller's multi-cycle access, then routes the one-cycle completion pulse and read data back to the winning port.

## Interface
- No parameters; port count fixed at 2; data 32 bits, address 32 bits, strobe 4 bits.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `s0_valid`, `s1_valid` in 1: port request; held until that port's `sN_ready`.
- `s0_ready`, `s1_ready` out 1: one-cycle completion pulse.
- `s0_addr`, `s1_addr` in 32: byte address.
- `s0_wdata`, `s1_wdata` in 32: write data.
- `s0_wstrb`, `s1_wstrb` in 4: byte strobes; 0 means read.
- `s0_rdata`, `s1_rdata` out 32: read data, valid while `sN_ready`=1.
- `m_valid` out 1: request to controller.
- `m_ready` in 1: controller completion pulse, exactly one cycle high.
- `m_addr` out 32, `m_wdata` out 32, `m_wstrb` out 4: registered request fields.
- `m_rdata` in 32: controller read data, valid with `m_ready`.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any `sN_valid`, pick the winner, load `m_addr`/`m_wdata`/`m_wstrb` from it, set `m_valid`=1, record `grant`, go BUSY. Otherwise stay.
- Arbitration: one requester wins outright. If both request, the port not equal to `last_grant` wins. `last_grant` updates on every grant.
- BUSY: `m_*` held constant. When `m_ready`=1: `m_valid`<=0; `s<grant>_ready`<=1; `s<grant>_rdata`<=`m_rdata` (captured for writes too; content don't-care); go DONE.
- DONE: clear both `sN_ready`, go IDLE unconditionally. This bubble lets the master drop `sN_valid` before IDLE samples again.
- The non-granted port's `sN_ready` stays 0 and its `sN_rdata` holds its last value.
- `m_ready` outside BUSY is ignored. No state change, no `sN_ready`.
- `sN_valid` deasserted during BUSY (protocol violation): the transaction still completes and the `ready` pulse is still issued.
- Reset, including mid-BUSY: state=IDLE, `m_valid`=0, `m_addr`/`m_wdata`=0, `m_wstrb`=0, `s0_ready`=`s1_ready`=0, `s0_rdata`=`s1_rdata`=0, `last_grant`=1 (port 0 wins the first contention). An in-flight controller access is abandoned. The controller is reset by the same `rst_n`.

## Timing
- `sN_valid` seen high at edge t (IDLE) -> `m_valid`=1 and `m_*` valid after edge t.
- `m_ready` high at edge u -> `sN_ready`=1 and `sN_rdata` valid after edge u, for exactly one cycle.
- Arbiter overhead: 1 cycle before the request plus 2 cycles after completion (response + DONE). The earliest next grant is sampled 2 edges after `m_ready`.
- `m_valid` is low in the cycle after `m_ready`. The controller therefore never sees a stale request as a new one.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Single module; no sub-module.
- Shared package holds the state encoding (IDLE=0, BUSY=1, DONE=2), the width constants (ADDR_W=32, DATA_W=32, STRB_W=4), and the port index type.

## Test plan
- Single read, port 0: `s0_valid`, addr 0x0000_1230, wstrb 0. The `m_ready` model returns 0xDEADBEEF after 8 cycles -> `m_addr`=0x0000_1230 one cycle after valid; `s0_ready` is a 1-cycle pulse with `s0_rdata`=0xDEADBEEF; `s1_ready` never asserts.
- Single write, port 1: addr 0x40, wdata 0xA5A5_0F0F, wstrb 0x3 -> `m_wstrb`=0x3 and `m_wdata`=0xA5A5_0F0F, stable for the whole of BUSY; `s1_ready` pulses once.
- Simultaneous requests after reset, both held for 4 transactions -> grant order 0,1,0,1; `m_valid` low for ≥2 cycles between each `m_ready` and the next grant.
- Port 0 requests continuously, port 1 idle -> port 0 is granted back-to-back with a 3-cycle turnaround; no starvation check needed.
- Spurious `m_ready` in IDLE -> no `sN_ready` and no state change.
- `rst_n` low for 1 cycle mid-BUSY -> all outputs return to the reset values above; the next request is granted normally and port 0 wins a tie.
